// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
//   Shared definitions for the ALU issue stage: the ALU opcode, instruction
//   field bit positions (big-endian numbering, bit 0 is the MSB), operand
//   width encodings, FSM state encodings, the held-entry record and the
//   writeback forwarding helper used for both capture and refresh.
package alu_issue_stage_pkg;

   localparam logic [0:5] ALU_OPCODE = 6'b101010;

   // Instruction field positions within instr[0:31]
   localparam int OPC_L = 0;
   localparam int OPC_R = 5;
   localparam int RD_L  = 6;
   localparam int RD_R  = 10;
   localparam int RA_L  = 11;
   localparam int RA_R  = 15;
   localparam int RB_L  = 16;
   localparam int RB_R  = 20;
   localparam int PPP_L = 21;
   localparam int PPP_R = 23;
   localparam int WW_L  = 24;
   localparam int WW_R  = 25;
   localparam int FN_L  = 26;
   localparam int FN_R  = 31;

   typedef enum logic [1:0] {
      WW_8  = 2'b00,
      WW_16 = 2'b01,
      WW_32 = 2'b10,
      WW_64 = 2'b11
   } ww_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,   // no entry held
      ST_BUSY = 2'b01,   // main valid
      ST_SKID = 2'b10    // main and skid valid
   } state_e;

   typedef struct packed {
      logic [0:5]  opcode;
      logic [0:5]  func;
      ww_e         ww;
      logic [0:4]  rd;
      logic [0:4]  ra;
      logic [0:4]  rb;
      logic [0:2]  ppp;
      logic [0:63] a_val;
      logic [0:63] b_val;
   } entry_t;

   // Returns wb_data when the writeback targets src, otherwise cur.
   function automatic logic [0:63] fwd(input logic [0:63] cur,
                                       input logic [0:4]  src,
                                       input logic        wb_en,
                                       input logic [0:4]  wb_addr,
                                       input logic [0:63] wb_data);
      return (wb_en && (wb_addr == src)) ? wb_data : cur;
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Downstream issue bus from the issue stage to the ALU / writeback.
//   master : issue stage (drives valid + payload, receives out_ready)
//   slave  : consumer    (receives valid + payload, drives out_ready)
interface alu_issue_stage_if;
   logic        out_valid;
   logic        out_ready;
   logic [0:63] rA_64bit_val;
   logic [0:63] rB_64bit_val;
   logic [0:5]  R_ins;
   logic [0:5]  Op_code;
   logic [0:1]  WW;
   logic [0:4]  rD_out;
   logic [0:2]  PPP_out;

   modport master (
      output out_valid, rA_64bit_val, rB_64bit_val, R_ins, Op_code, WW,
             rD_out, PPP_out,
      input  out_ready
   );

   modport slave (
      input  out_valid, rA_64bit_val, rB_64bit_val, R_ins, Op_code, WW,
             rD_out, PPP_out,
      output out_ready
   );
endinterface

// File: rtl/alu_issue_stage_entry.sv
// alu_issue_entry
//   One held instruction slot (used for both main and skid).
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     instr             incoming instruction word
//     rf_a/b_data       register file data for instr's rA / rB
//     wb_en/addr/data   writeback port (forwarding on capture, refresh when held)
//     held              slot currently holds a valid entry
//     load_new          capture instr with operands (forwarded if needed)
//     load_move         take move_in (the other slot), refreshed this cycle
//     move_in           source entry for load_move
//     entry_q           registered slot contents
import alu_issue_stage_pkg::*;

module alu_issue_entry (
   input  logic        clk,
   input  logic        rst,
   input  logic [0:31] instr,
   input  logic [0:63] rf_a_data,
   input  logic [0:63] rf_b_data,
   input  logic        wb_en,
   input  logic [0:4]  wb_addr,
   input  logic [0:63] wb_data,
   input  logic        held,
   input  logic        load_new,
   input  logic        load_move,
   input  entry_t      move_in,
   output entry_t      entry_q
);

   entry_t entry_d;

   always_comb begin
      entry_d = entry_q;
      if (load_new) begin
         entry_d.opcode = instr[OPC_L:OPC_R];
         entry_d.func   = instr[FN_L:FN_R];
         entry_d.ww     = ww_e'(instr[WW_L:WW_R]);
         entry_d.rd     = instr[RD_L:RD_R];
         entry_d.ra     = instr[RA_L:RA_R];
         entry_d.rb     = instr[RB_L:RB_R];
         entry_d.ppp    = instr[PPP_L:PPP_R];
         // Same-cycle writeback wins over the (stale) register file read.
         entry_d.a_val  = fwd(rf_a_data, instr[RA_L:RA_R], wb_en, wb_addr, wb_data);
         entry_d.b_val  = fwd(rf_b_data, instr[RB_L:RB_R], wb_en, wb_addr, wb_data);
      end else if (load_move) begin
         // The source slot is still held this cycle, so its refresh is
         // applied on the way across rather than lost.
         entry_d       = move_in;
         entry_d.a_val = fwd(move_in.a_val, move_in.ra, wb_en, wb_addr, wb_data);
         entry_d.b_val = fwd(move_in.b_val, move_in.rb, wb_en, wb_addr, wb_data);
      end else if (held) begin
         entry_d.a_val = fwd(entry_q.a_val, entry_q.ra, wb_en, wb_addr, wb_data);
         entry_d.b_val = fwd(entry_q.b_val, entry_q.rb, wb_en, wb_addr, wb_data);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entry_q <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Accepts instructions from upstream, drops (and counts) non-ALU opcodes,
//   captures operands with writeback forwarding, keeps them fresh while held
//   and issues them in order through a main register backed by one skid slot.
//   Ports:
//     clk, rst                   clock, asynchronous active-low reset
//     instr_in, in_valid         upstream instruction and valid
//     in_ready                   registered ready, low only when both slots full
//     rf_rA_addr, rf_rB_addr     register file read addresses (from instr_in)
//     rf_rA_data, rf_rB_data     register file read data (same cycle)
//     wb_en, wb_addr, wb_data    writeback port
//     illegal_cnt                saturating count of dropped instructions
//     iss                        downstream issue bus (master side)
import alu_issue_stage_pkg::*;

module alu_issue_stage (
   input  logic                clk,
   input  logic                rst,
   input  logic [0:31]         instr_in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [0:4]          rf_rA_addr,
   output logic [0:4]          rf_rB_addr,
   input  logic [0:63]         rf_rA_data,
   input  logic [0:63]         rf_rB_data,
   input  logic                wb_en,
   input  logic [0:4]          wb_addr,
   input  logic [0:63]         wb_data,
   output logic [0:15]         illegal_cnt,
   alu_issue_stage_if.master   iss
);

   localparam int MAIN_IDX = 0;
   localparam int SKID_IDX = 1;

   state_e      state_q, state_d;
   logic        in_ready_q, in_ready_d;
   logic [0:15] cnt_q, cnt_d;

   logic [1:0]  ent_new;
   logic [1:0]  ent_move;
   logic [1:0]  ent_held;
   entry_t      ent_q [2];

   logic        accept;
   logic        is_alu;

   assign rf_rA_addr = instr_in[RA_L:RA_R];
   assign rf_rB_addr = instr_in[RB_L:RB_R];

   assign accept = in_valid && in_ready_q;
   assign is_alu = (instr_in[OPC_L:OPC_R] == ALU_OPCODE);

   always_comb begin
      state_d  = state_q;
      ent_new  = '0;
      ent_move = '0;
      cnt_d    = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (accept && is_alu) begin
               state_d           = ST_BUSY;
               ent_new[MAIN_IDX] = 1'b1;
            end
         end
         ST_BUSY: begin
            if (iss.out_ready) begin
               if (accept && is_alu) begin
                  ent_new[MAIN_IDX] = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (accept && is_alu) begin
               state_d           = ST_SKID;
               ent_new[SKID_IDX] = 1'b1;
            end
         end
         ST_SKID: begin
            if (iss.out_ready) begin
               state_d            = ST_BUSY;
               ent_move[MAIN_IDX] = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Dropped instructions leave the FSM untouched in every state.
      if (accept && !is_alu && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end

      // Registered ready looks at the next state only, so it never has a
      // combinational path from out_ready.
      in_ready_d = (state_d != ST_SKID);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         in_ready_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ent_held[MAIN_IDX] = (state_q != ST_IDLE);
   assign ent_held[SKID_IDX] = (state_q == ST_SKID);

   // Slot 0 is main, slot 1 is skid; only main ever takes a move (from skid).
   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      alu_issue_entry u_entry (
         .clk       (clk),
         .rst       (rst),
         .instr     (instr_in),
         .rf_a_data (rf_rA_data),
         .rf_b_data (rf_rB_data),
         .wb_en     (wb_en),
         .wb_addr   (wb_addr),
         .wb_data   (wb_data),
         .held      (ent_held[gi]),
         .load_new  (ent_new[gi]),
         .load_move (ent_move[gi]),
         .move_in   (ent_q[SKID_IDX]),
         .entry_q   (ent_q[gi])
      );
   end

   assign in_ready         = in_ready_q;
   assign illegal_cnt      = cnt_q;
   assign iss.out_valid    = (state_q != ST_IDLE);
   assign iss.rA_64bit_val = ent_q[MAIN_IDX].a_val;
   assign iss.rB_64bit_val = ent_q[MAIN_IDX].b_val;
   assign iss.R_ins        = ent_q[MAIN_IDX].func;
   assign iss.Op_code      = ent_q[MAIN_IDX].opcode;
   assign iss.WW           = ent_q[MAIN_IDX].ww;
   assign iss.rD_out       = ent_q[MAIN_IDX].rd;
   assign iss.PPP_out      = ent_q[MAIN_IDX].ppp;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Directed and randomized bench for alu_issue_stage. The reference model is
//   a queue of accepted ALU instructions plus a register file array: every
//   issued instruction must be the queue head, with operands equal to the
//   register file contents at the moment it is issued.
module tb_alu_issue_stage;

   localparam logic [0:5] LEGAL_OP = 6'b101010;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:31] instr_in;
   logic        in_valid;
   logic        in_ready;
   logic [0:4]  rf_rA_addr, rf_rB_addr;
   logic [0:63] rf_rA_data, rf_rB_data;
   logic        wb_en;
   logic [0:4]  wb_addr;
   logic [0:63] wb_data;
   logic [0:15] illegal_cnt;

   alu_issue_stage_if iss ();

   alu_issue_stage dut (
      .clk         (clk),
      .rst         (rst),
      .instr_in    (instr_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .rf_rA_addr  (rf_rA_addr),
      .rf_rB_addr  (rf_rB_addr),
      .rf_rA_data  (rf_rA_data),
      .rf_rB_data  (rf_rB_data),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .illegal_cnt (illegal_cnt),
      .iss         (iss)
   );

   always #5 clk = ~clk;

   // Bench-owned register file; writes land just after the clock edge.
   logic [0:63] regs [32];
   assign rf_rA_data = regs[instr_in[11:15]];
   assign rf_rB_data = regs[instr_in[16:20]];

   logic [0:31] exp_q [$];
   int          exp_cnt;
   int          vectors;
   int          miscompares;

   function automatic logic [0:31] mk(input logic [0:5] op, input logic [0:4] rd,
                                      input logic [0:4] ra, input logic [0:4] rb,
                                      input logic [0:2] ppp, input logic [0:1] ww,
                                      input logic [0:5] fn);
      return {op, rd, ra, rb, ppp, ww, fn};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: check at the falling edge, update the model for what the
   // coming rising edge does, then apply any writeback to the register file.
   task automatic cycle();
      logic        exp_ready;
      logic [0:31] e;
      logic        we;
      logic [0:4]  wa;
      logic [0:63] wd;
      @(negedge clk);
      exp_ready = (exp_q.size() < 2);
      chk("out_valid", 64'(iss.out_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
      chk("rf_rA_addr", 64'(rf_rA_addr), 64'(instr_in[11:15]));
      chk("rf_rB_addr", 64'(rf_rB_addr), 64'(instr_in[16:20]));
      if ((exp_q.size() != 0) && iss.out_ready) begin
         e = exp_q.pop_front();
         chk("issue_rA", iss.rA_64bit_val, regs[e[11:15]]);
         chk("issue_rB", iss.rB_64bit_val, regs[e[16:20]]);
         chk("issue_R_ins", 64'(iss.R_ins), 64'(e[26:31]));
         chk("issue_Op_code", 64'(iss.Op_code), 64'(e[0:5]));
         chk("issue_WW", 64'(iss.WW), 64'(e[24:25]));
         chk("issue_rD", 64'(iss.rD_out), 64'(e[6:10]));
         chk("issue_PPP", 64'(iss.PPP_out), 64'(e[21:23]));
      end
      if (in_valid && exp_ready) begin
         if (instr_in[0:5] == LEGAL_OP) exp_q.push_back(instr_in);
         else if (exp_cnt != 16'hFFFF) exp_cnt++;
      end
      we = wb_en;
      wa = wb_addr;
      wd = wb_data;
      @(posedge clk);
      #1;
      if (we) regs[wa] = wd;
   endtask

   initial begin
      logic [0:5] op;
      vectors     = 0;
      miscompares = 0;
      exp_cnt     = 0;
      for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
      regs[1] = 64'd5;
      regs[2] = 64'd10;
      regs[3] = 64'd7;
      rst           = 1'b0;
      in_valid      = 1'b0;
      instr_in      = '0;
      wb_en         = 1'b0;
      wb_addr       = '0;
      wb_data       = '0;
      iss.out_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_out_valid", 64'(iss.out_valid), 64'd0);
      chk("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
      chk("rst_rA", iss.rA_64bit_val, 64'd0);
      chk("rst_R_ins", 64'(iss.R_ins), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // VADD with latency 1
      iss.out_ready = 1'b1;
      instr_in = mk(LEGAL_OP, 5'd9, 5'd1, 5'd2, 3'd0, 2'b00, 6'b000110);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("vadd_valid", 64'(iss.out_valid), 64'd1);
      chk("vadd_rA", iss.rA_64bit_val, 64'd5);
      chk("vadd_rB", iss.rB_64bit_val, 64'd10);
      chk("vadd_R_ins", 64'(iss.R_ins), 64'b000110);
      chk("vadd_WW", 64'(iss.WW), 64'b00);
      cycle();

      // Same-cycle writeback forwarding
      instr_in = mk(LEGAL_OP, 5'd5, 5'd4, 5'd2, 3'd1, 2'b11, 6'b000111);
      in_valid = 1'b1;
      wb_en    = 1'b1;
      wb_addr  = 5'd4;
      wb_data  = 64'hFFFFFFFF_00000000;
      cycle();
      in_valid = 1'b0;
      wb_en    = 1'b0;
      chk("fwd_rA", iss.rA_64bit_val, 64'hFFFFFFFF_00000000);
      cycle();

      // Fill main and skid, stall a third, then drain in order
      iss.out_ready = 1'b0;
      instr_in = mk(LEGAL_OP, 5'd1, 5'd1, 5'd2, 3'd2, 2'b01, 6'd1);
      in_valid = 1'b1;
      cycle();
      instr_in = mk(LEGAL_OP, 5'd2, 5'd2, 5'd1, 3'd3, 2'b10, 6'd2);
      cycle();
      chk("skid_in_ready", 64'(in_ready), 64'd0);
      instr_in = mk(LEGAL_OP, 5'd3, 5'd3, 5'd4, 3'd4, 2'b11, 6'd3);
      repeat (3) cycle();
      iss.out_ready = 1'b1;
      cycle();
      cycle();
      in_valid = 1'b0;
      repeat (2) cycle();

      // Refresh of a held rB
      iss.out_ready = 1'b0;
      instr_in = mk(LEGAL_OP, 5'd7, 5'd1, 5'd3, 3'd5, 2'b10, 6'd9);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      wb_en    = 1'b1;
      wb_addr  = 5'd3;
      wb_data  = 64'd20;
      cycle();
      wb_en = 1'b0;
      cycle();
      chk("refresh_rB", iss.rB_64bit_val, 64'd20);
      iss.out_ready = 1'b1;
      repeat (2) cycle();

      // Single illegal opcode
      instr_in = mk(6'b000000, 5'd1, 5'd1, 5'd1, 3'd0, 2'b00, 6'd0);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("illegal_one", 64'(illegal_cnt), 64'd1);
      chk("illegal_no_issue", 64'(iss.out_valid), 64'd0);
      cycle();

      // Asynchronous reset while in SKID
      iss.out_ready = 1'b0;
      instr_in = mk(LEGAL_OP, 5'd4, 5'd5, 5'd6, 3'd1, 2'b01, 6'd4);
      in_valid = 1'b1;
      cycle();
      instr_in = mk(LEGAL_OP, 5'd5, 5'd6, 5'd5, 3'd2, 2'b10, 6'd5);
      cycle();
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(iss.out_valid), 64'd0);
      chk("async_rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
      chk("async_rst_rA", iss.rA_64bit_val, 64'd0);
      exp_q.delete();
      exp_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      iss.out_ready = 1'b1;
      repeat (4) cycle();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         op = ($urandom_range(0, 9) < 8) ? LEGAL_OP : 6'($urandom_range(0, 41));
         instr_in = mk(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
         in_valid      = ($urandom_range(0, 9) < 7);
         iss.out_ready = ($urandom_range(0, 9) < 6);
         wb_en         = ($urandom_range(0, 9) < 4);
         wb_addr       = 5'($urandom_range(0, 7));
         wb_data       = {$urandom, $urandom};
         cycle();
      end
      in_valid      = 1'b0;
      wb_en         = 1'b0;
      iss.out_ready = 1'b1;
      repeat (4) cycle();

      // Saturation of the illegal counter
      instr_in = mk(6'b000000, 5'd0, 5'd0, 5'd0, 3'd0, 2'b00, 6'd0);
      in_valid = 1'b1;
      repeat (65540) cycle();
      in_valid = 1'b0;
      chk("illegal_saturate", 64'(illegal_cnt), 64'hFFFF);
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 instr_in  input  [0:31]  instruction: [0:5] opcode, [6:10] rD, [11:15] rA, [16:20] rB, [21:23] PPP, [24:25] WW, [26:31] function.
REQ-004 in_valid / in_ready  input / output  1  upstream handshake; transfer when both high at a clock edge.
REQ-005 rf_rA_addr, rf_rB_addr  output  [0:4]  register-file read addresses, combinational from instr_in.
REQ-006 rf_rA_data, rf_rB_data  input  [0:63]  register-file read data, same cycle.
REQ-007 wb_en, wb_addr [0:4], wb_data [0:63]  input  writeback port, used for forwarding and refresh.
REQ-008 rA_64bit_val, rB_64bit_val  output  [0:63]  registered ALU operands.
REQ-009 R_ins, Op_code  output  [0:5]  registered function and opcode; WW output [0:1]; rD_out [0:4]; PPP_out [0:2].
REQ-010 out_valid / out_ready  output / input  1  downstream handshake to ALU/writeback.
REQ-011 illegal_cnt  output  [0:15]  count of dropped non-ALU instructions.

Function
REQ-012 Only opcode 6'b101010 is accepted as an ALU instruction; any other accepted opcode is consumed (in_ready honoured), not issued, and increments illegal_cnt.
REQ-013 illegal_cnt saturates at 16'hFFFF.
REQ-014 Operand capture: if wb_en and wb_addr equals the source address, wb_data is captured; otherwise rf data.
REQ-015 Storage: one output register (main) plus one skid register; states IDLE (none valid), BUSY (main valid), SKID (both valid).
REQ-016 IDLE: legal accept -> BUSY, out_valid high the next cycle (latency 1).
REQ-017 BUSY: out_ready & legal accept -> BUSY with new entry; out_ready & no accept -> IDLE; !out_ready & legal accept -> SKID (entry into skid).
REQ-018 SKID: in_ready low; out_ready -> skid moves to main, BUSY.
REQ-019 in_ready is registered, low only in SKID state; never depends combinationally on out_ready.
REQ-020 Outputs hold stable while out_valid & !out_ready.
REQ-021 Refresh: each cycle an entry is held in main or skid, if wb_en and wb_addr equals that entry's rA (rB) source, the held operand is replaced by wb_data; rA and rB refresh independently.
REQ-022 Refresh of main is suppressed in the cycle main is consumed and reloaded; the new entry uses REQ-014.
REQ-023 Instruction order is preserved; no entry is lost or duplicated.
REQ-024 Illegal instruction arriving in SKID-bound condition is still dropped and counted; state unchanged.

Reset
REQ-025 rst low: state IDLE, out_valid 0, in_ready 1 after release, all data outputs 0, illegal_cnt 0, immediately and independent of clk.
REQ-026 Reset mid-transfer discards main and skid contents; no partial issue after release.

Structure
REQ-027 Shared package holds opcode constant ALU_OPCODE = 6'b101010, instruction field bit positions, WW encodings (00 8-bit, 01 16-bit, 10 32-bit, 11 64-bit) and state encodings.
REQ-028 One sub-module: alu_issue_entry (operand capture + refresh logic), instantiated for main and skid.

Verification
REQ-029 Reset then one VADD (function 000110, WW 00, rA data 64'd5, rB data 64'd10) with out_ready 1 -> next cycle out_valid 1, operands 5/10, R_ins 000110, WW 00.
REQ-030 wb_en=1, wb_addr=rA addr, wb_data 64'hFFFFFFFF_00000000 same cycle as accept -> rA_64bit_val 64'hFFFFFFFF_00000000.
REQ-031 out_ready 0, two back-to-back legal instrs -> state SKID, in_ready 0 next cycle, third instr stalls; out_ready 1 -> three issued in order.
REQ-032 Hold entry with rB=r3 under out_ready 0, then wb_en to r3 with 64'd20 -> issued rB_64bit_val 64'd20.
REQ-033 Opcode 6'b000000 accepted -> no out_valid, illegal_cnt 1; 65536 such -> illegal_cnt stays 16'hFFFF.
REQ-034 rst asserted in SKID state -> out_valid 0 immediately, nothing issued after release.
